// File: rtl/memory_game_pkg.sv
// Shared types and constants for the 4x4 memory-match game logic.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package memory_game_pkg;

  typedef enum logic [1:0] {
    FIRST  = 2'd0,
    SECOND = 2'd1,
    SHOW   = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef logic [3:0] cell_t;

  localparam int         NUM_CELLS   = 16;
  localparam cell_t      CELL_HIDDEN = 4'd0;
  localparam logic [3:0] NUM_PAIRS   = 4'd8;

  // Fixed symbol placement, row-major; each symbol id 1..8 appears exactly twice.
  localparam cell_t LAYOUT [NUM_CELLS] = '{
    4'd1, 4'd2, 4'd3, 4'd4,
    4'd5, 4'd6, 4'd7, 4'd8,
    4'd6, 4'd2, 4'd7, 4'd4,
    4'd8, 4'd1, 4'd5, 4'd3
  };

endpackage

// File: rtl/cursor_ctrl.sv
// Cursor position on the 4x4 board: 2-bit row/column wrap counters.
// Latency: a move pulse sampled at an edge is reflected in block after that edge.
// Backpressure: none; moves are dropped while hold is high, restart wins over moves.
module cursor_ctrl
  import memory_game_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       move_right,
  input  logic       move_down,
  input  logic       hold,
  input  logic       restart,
  output logic [3:0] block
);

  logic [1:0] row_q, row_d;
  logic [1:0] col_q, col_d;

  // Next cursor: restart clears, otherwise each axis wraps modulo 4 independently.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (restart) begin
      row_d = 2'd0;
      col_d = 2'd0;
    end else if (!hold) begin
      if (move_down)  row_d = row_q + 2'd1;
      if (move_right) col_d = col_q + 2'd1;
    end
  end

  // Cursor registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= 2'd0;
      col_q <= 2'd0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign block = {row_q, col_q};

endmodule

// File: rtl/memory_board_ctrl.sv
// Memory-match game logic feeding the VGA renderer: cell faces, cursor, reveal/compare/hide.
// Latency: every output is registered; a button pulse sampled at edge t shows after edge t.
// Backpressure: none; selects that are not legal in the current state are dropped.
module memory_board_ctrl
  import memory_game_pkg::*;
#(
  parameter int HOLD_CYCLES = 25_000_000,
  parameter int TMR_W       = 25
) (
  input  logic       VGA_CLK_IN,
  input  logic       rst,
  input  logic       btn_right,
  input  logic       btn_down,
  input  logic       btn_sel,
  output logic [3:0] c1,
  output logic [3:0] c2,
  output logic [3:0] c3,
  output logic [3:0] c4,
  output logic [3:0] c5,
  output logic [3:0] c6,
  output logic [3:0] c7,
  output logic [3:0] c8,
  output logic [3:0] c9,
  output logic [3:0] c10,
  output logic [3:0] c11,
  output logic [3:0] c12,
  output logic [3:0] c13,
  output logic [3:0] c14,
  output logic [3:0] c15,
  output logic [3:0] c16,
  output logic [3:0] block,
  output logic [3:0] pairs_found,
  output logic [7:0] attempts,
  output logic       game_done
);

  state_t           state_q, state_d;
  cell_t            cells_q [NUM_CELLS];
  cell_t            cells_d [NUM_CELLS];
  logic [3:0]       first_idx_q, first_idx_d;
  logic [3:0]       second_idx_q, second_idx_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [3:0]       pairs_q, pairs_d;
  logic [7:0]       attempts_q, attempts_d;
  logic             done_q;
  logic [3:0]       cur;
  logic             restart;

  // A select in DONE restarts the game; the cursor is frozen while DONE.
  assign restart = (state_q == DONE) && btn_sel;

  cursor_ctrl u_cursor (
    .clk        (VGA_CLK_IN),
    .rst_n      (rst),
    .move_right (btn_right),
    .move_down  (btn_down),
    .hold       (state_q == DONE),
    .restart    (restart),
    .block      (cur)
  );

  // Game FSM: selects act on the pre-move cursor (cur is the registered position).
  always_comb begin
    state_d      = state_q;
    cells_d      = cells_q;
    first_idx_d  = first_idx_q;
    second_idx_d = second_idx_q;
    timer_d      = timer_q;
    pairs_d      = pairs_q;
    attempts_d   = attempts_q;
    case (state_q)
      FIRST: begin
        if (btn_sel && cells_q[cur] == CELL_HIDDEN) begin
          cells_d[cur] = LAYOUT[cur];
          first_idx_d  = cur;
          state_d      = SECOND;
        end
      end
      SECOND: begin
        // A hidden cell can never be first_idx, so no explicit same-cell test.
        if (btn_sel && cells_q[cur] == CELL_HIDDEN) begin
          cells_d[cur] = LAYOUT[cur];
          if (attempts_q != 8'hFF) attempts_d = attempts_q + 8'd1;
          if (LAYOUT[cur] == LAYOUT[first_idx_q]) begin
            pairs_d = pairs_q + 4'd1;
            state_d = (pairs_q + 4'd1 == NUM_PAIRS) ? DONE : FIRST;
          end else begin
            timer_d      = TMR_W'(HOLD_CYCLES - 1);
            second_idx_d = cur;
            state_d      = SHOW;
          end
        end
      end
      SHOW: begin
        // Load of HOLD_CYCLES-1 plus the zero cycle gives exactly HOLD_CYCLES face-up cycles.
        if (timer_q == '0) begin
          cells_d[first_idx_q]  = CELL_HIDDEN;
          cells_d[second_idx_q] = CELL_HIDDEN;
          state_d               = FIRST;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      DONE: begin
        if (btn_sel) begin
          for (int i = 0; i < NUM_CELLS; i++) cells_d[i] = CELL_HIDDEN;
          pairs_d    = 4'd0;
          attempts_d = 8'd0;
          state_d    = FIRST;
        end
      end
      default: state_d = FIRST;
    endcase
  end

  // State, board and counter registers.
  always_ff @(posedge VGA_CLK_IN or negedge rst) begin
    if (!rst) begin
      state_q      <= FIRST;
      for (int i = 0; i < NUM_CELLS; i++) cells_q[i] <= CELL_HIDDEN;
      first_idx_q  <= 4'd0;
      second_idx_q <= 4'd0;
      timer_q      <= '0;
      pairs_q      <= 4'd0;
      attempts_q   <= 8'd0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cells_q      <= cells_d;
      first_idx_q  <= first_idx_d;
      second_idx_q <= second_idx_d;
      timer_q      <= timer_d;
      pairs_q      <= pairs_d;
      attempts_q   <= attempts_d;
      done_q       <= (state_d == DONE);
    end
  end

  assign c1          = cells_q[0];
  assign c2          = cells_q[1];
  assign c3          = cells_q[2];
  assign c4          = cells_q[3];
  assign c5          = cells_q[4];
  assign c6          = cells_q[5];
  assign c7          = cells_q[6];
  assign c8          = cells_q[7];
  assign c9          = cells_q[8];
  assign c10         = cells_q[9];
  assign c11         = cells_q[10];
  assign c12         = cells_q[11];
  assign c13         = cells_q[12];
  assign c14         = cells_q[13];
  assign c15         = cells_q[14];
  assign c16         = cells_q[15];
  assign block       = cur;
  assign pairs_found = pairs_q;
  assign attempts    = attempts_q;
  assign game_done   = done_q;

endmodule

// File: tb/tb_memory_board_ctrl.sv
// Scoreboard bench for memory_board_ctrl: driver pushes model snapshots, monitor compares.
// Latency: one expected snapshot per clock edge, compared on the following falling edge.
// Backpressure: n/a.
module tb_memory_board_ctrl;

  localparam int HOLD = 4;
  localparam int LAY [16] = '{1, 2, 3, 4, 5, 6, 7, 8, 6, 2, 7, 4, 8, 1, 5, 3};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic br = 1'b0, bd = 1'b0, bs = 1'b0;
  logic [3:0] c1, c2, c3, c4, c5, c6, c7, c8, c9, c10, c11, c12, c13, c14, c15, c16;
  logic [3:0] blk, pairs;
  logic [7:0] att;
  logic       done;
  logic [63:0] dut_cells;

  assign dut_cells = {c16, c15, c14, c13, c12, c11, c10, c9, c8, c7, c6, c5, c4, c3, c2, c1};

  memory_board_ctrl #(.HOLD_CYCLES(HOLD), .TMR_W(3)) dut (
    .VGA_CLK_IN (clk),
    .rst        (rst_n),
    .btn_right  (br),
    .btn_down   (bd),
    .btn_sel    (bs),
    .c1 (c1), .c2 (c2), .c3 (c3), .c4 (c4),
    .c5 (c5), .c6 (c6), .c7 (c7), .c8 (c8),
    .c9 (c9), .c10 (c10), .c11 (c11), .c12 (c12),
    .c13 (c13), .c14 (c14), .c15 (c15), .c16 (c16),
    .block       (blk),
    .pairs_found (pairs),
    .attempts    (att),
    .game_done   (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] cells;
    logic [3:0]  blk;
    logic [3:0]  pairs;
    logic [7:0]  att;
    logic        done;
  } snap_t;

  snap_t exp_q [$];
  int checks = 0;
  int errors = 0;

  // Reference model: board as an array of faces, cursor as row/col, a countdown for the hold.
  int m_face [16];
  int m_row, m_col, m_first, m_second, m_hold, m_pairs, m_att;
  bit m_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_face[i] = 0;
    m_row = 0; m_col = 0; m_first = -1; m_second = -1;
    m_hold = 0; m_pairs = 0; m_att = 0; m_done = 0;
  endtask

  task automatic model_step(input bit r, input bit d, input bit s);
    int cur;
    if (m_done) begin
      if (s) model_reset();
      return;
    end
    cur = m_row * 4 + m_col;
    if (m_hold > 0) begin
      m_hold--;
      if (m_hold == 0) begin
        m_face[m_first] = 0;
        m_face[m_second] = 0;
        m_first = -1;
      end
    end else if (s && m_face[cur] == 0) begin
      m_face[cur] = LAY[cur];
      if (m_first < 0) begin
        m_first = cur;
      end else begin
        if (m_att < 255) m_att++;
        if (LAY[cur] == LAY[m_first]) begin
          m_pairs++;
          m_first = -1;
          if (m_pairs == 8) m_done = 1;
        end else begin
          m_second = cur;
          m_hold = HOLD;
        end
      end
    end
    if (r) m_col = (m_col + 1) % 4;
    if (d) m_row = (m_row + 1) % 4;
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    s.cells = '0;
    for (int i = 0; i < 16; i++) s.cells[i*4 +: 4] = 4'(m_face[i]);
    s.blk   = 4'(m_row * 4 + m_col);
    s.pairs = 4'(m_pairs);
    s.att   = 8'(m_att);
    s.done  = m_done;
    return s;
  endfunction

  // Monitor: every falling edge with an outstanding expectation compares the DUT outputs.
  always @(negedge clk) begin
    snap_t e;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("cells", dut_cells, e.cells);
      chk("block", 64'(blk), 64'(e.blk));
      chk("pairs_found", 64'(pairs), 64'(e.pairs));
      chk("attempts", 64'(att), 64'(e.att));
      chk("game_done", 64'(done), 64'(e.done));
    end
  end

  // One-cycle button pulse; the model advances on the same edge and queues its expectation.
  task automatic step(input bit r, input bit d, input bit s);
    @(negedge clk);
    br = r; bd = d; bs = s;
    @(posedge clk);
    model_step(r, d, s);
    exp_q.push_back(model_snap());
    #1;
    br = 1'b0; bd = 1'b0; bs = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic goto_cell(input int idx);
    for (int k = 0; k < 8 && (m_row * 4 + m_col) != idx; k++)
      step(m_col != idx % 4, m_row != idx / 4, 0);
  endtask

  task automatic select(input int idx);
    goto_cell(idx);
    step(0, 0, 1);
  endtask

  task automatic chk_live_reset(input string tag);
    chk({tag, "_cells"}, dut_cells, 64'd0);
    chk({tag, "_block"}, 64'(blk), 64'd0);
    chk({tag, "_pairs"}, 64'(pairs), 64'd0);
    chk({tag, "_attempts"}, 64'(att), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
  endtask

  // Asynchronous reset asserted between edges; outputs are checked before any clock edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_live_reset(tag);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int pair_a [8] = '{0, 1, 2, 3, 4, 5, 6, 7};
  int pair_b [8] = '{13, 9, 15, 11, 14, 8, 10, 12};

  initial begin
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_live_reset("por");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Cursor wrap in both axes, then a combined move.
    repeat (4) step(1, 0, 0);
    step(1, 1, 0);
    repeat (4) step(0, 1, 0);

    // Matching pair stays up with no hold period.
    do_reset("rst_match");
    select(0);
    select(13);
    idle(3);
    select(0);
    idle(2);

    // Mismatch: face-up for HOLD cycles, select during the hold is ignored.
    do_reset("rst_mismatch");
    select(0);
    select(1);
    step(0, 0, 1);
    idle(6);

    // Select with move in the same cycle uses the pre-move cursor.
    step(1, 1, 1);
    idle(2);

    // Reselecting the first cell in SECOND is ignored.
    do_reset("rst_ignore");
    select(2);
    step(0, 0, 1);
    select(15);
    select(2);
    idle(2);

    // Full game, moves frozen in DONE, restart on select.
    do_reset("rst_full");
    for (int p = 0; p < 8; p++) begin
      select(pair_a[p]);
      select(pair_b[p]);
    end
    step(1, 1, 0);
    step(0, 1, 0);
    step(0, 0, 1);
    idle(2);

    // Random play against the model.
    do_reset("rst_rand");
    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);

    // Async reset in the middle of a hold.
    do_reset("rst_pre_show");
    select(0);
    select(1);
    idle(1);
    do_reset("rst_in_show");
    idle(3);

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
